// File: rtl/nanorv32_ahb_mem_slave_pkg.sv
// Shared AHB-lite encodings, responder FSM states and data-phase payload
// for the nanorv32 memory-side slaves.
package nanorv32_ahb_mem_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    // Attributes of the legal transfer currently in its data phase
    typedef struct packed {
        logic       valid;
        logic       write;
        logic [3:0] be;
    } dph_t;

endpackage

// File: rtl/nanorv32_ahb_mem_slave_if.sv
// AHB-lite slave-side bus bundle between the interconnect and one memory responder.
interface nanorv32_ahb_mem_slave_if;

    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/nanorv32_ahb_addr_check.sv
// Combinational AHB address decode: region/size/alignment legality, byte
// enables and word index inside the region. Shared by memory and peripheral slaves.
module nanorv32_ahb_addr_check
    import nanorv32_ahb_mem_slave_pkg::*;
#(
    parameter int unsigned MEM_AW    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic [31:0]       haddr,
    input  logic [2:0]        hsize,
    output logic              ok_c,
    output logic [3:0]        be_c,
    output logic [MEM_AW-1:0] word_c
);

    localparam int unsigned SPAN_SH = MEM_AW + 2;

    logic [31:0] offset;
    logic        in_range;
    logic        aligned;

    // Offset subtraction wraps addresses below BASE_ADDR out of range too
    always_comb begin
        offset   = haddr - BASE_ADDR;
        in_range = (offset >> SPAN_SH) == 32'd0;
        aligned  = 1'b0;
        be_c     = 4'b0000;
        case (hsize)
            HSIZE_BYTE: begin
                aligned = 1'b1;
                be_c    = 4'b0001 << haddr[1:0];
            end
            HSIZE_HALF: begin
                aligned = ~haddr[0];
                be_c    = 4'b0011 << haddr[1:0];
            end
            HSIZE_WORD: begin
                aligned = (haddr[1:0] == 2'b00);
                be_c    = 4'b1111;
            end
            default: ;
        endcase
        ok_c   = in_range & aligned;
        word_c = offset[SPAN_SH-1:2];
    end

endmodule

// File: rtl/nanorv32_ahb_mem_slave.sv
// AHB-lite responder in front of a single-port synchronous SRAM with
// configurable wait states, read/write port-conflict deferral and ERROR responses.
module nanorv32_ahb_mem_slave
    import nanorv32_ahb_mem_slave_pkg::*;
#(
    parameter int unsigned MEM_AW      = 14,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nanorv32_ahb_mem_slave_if.slave  bus,
    output logic                     mem_cs,
    output logic                     mem_we,
    output logic [3:0]               mem_be,
    output logic [MEM_AW-1:0]        mem_addr,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata
);

    localparam logic [2:0] WS_FULL  = 3'(WAIT_STATES);
    localparam logic [2:0] WS_LESS  = 3'(WAIT_STATES - 1);
    localparam bit         HAS_WAIT = (WAIT_STATES != 0);

    logic [1:0]        state, state_n;
    logic [2:0]        cnt, cnt_n;
    dph_t              dph, dph_n;
    logic [MEM_AW-1:0] dph_word, dph_word_n;
    logic              pending, pending_n;
    logic              rd_cap;
    logic              ready_reg, ready_n;
    logic              resp_reg, resp_n;
    logic [31:0]       rdata_reg;

    logic              ok_c;
    logic [3:0]        be_c;
    logic [MEM_AW-1:0] word_c;
    logic              decode_c;
    logic              wr_now_c;
    logic              rd_issue_c;
    logic              unused_htrans;

    nanorv32_ahb_addr_check #(
        .MEM_AW    (MEM_AW),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_check (
        .haddr  (bus.haddr),
        .hsize  (bus.hsize),
        .ok_c   (ok_c),
        .be_c   (be_c),
        .word_c (word_c)
    );

    // Address phases are only decoded while we are not stalling our own data phase
    assign decode_c      = rst_n & bus.hsel & bus.htrans[1] & bus.hready & ready_reg;
    assign wr_now_c      = dph.valid & dph.write & ready_reg;
    assign rd_issue_c    = decode_c & ok_c & ~bus.hwrite & ~wr_now_c;
    assign unused_htrans = bus.htrans[0];

    // SRAM port: completing write first, then a deferred read, then a fresh read
    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = word_c;
        mem_wdata = bus.hwdata;
        if (wr_now_c) begin
            mem_cs   = 1'b1;
            mem_we   = 1'b1;
            mem_be   = dph.be;
            mem_addr = dph_word;
        end else if (pending) begin
            mem_cs   = 1'b1;
            mem_addr = dph_word;
        end else if (rd_issue_c) begin
            mem_cs = 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        dph_n      = dph;
        dph_word_n = dph_word;
        pending_n  = 1'b0;
        ready_n    = 1'b1;
        resp_n     = HRESP_OKAY;
        case (state)
            ST_WAIT: begin
                if (cnt == 3'd0) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n   = cnt - 3'd1;
                    ready_n = 1'b0;
                end
            end
            ST_ERR1: begin
                state_n = ST_ERR2;
                resp_n  = HRESP_ERROR;
            end
            ST_IDLE, ST_ERR2: begin
                state_n   = ST_IDLE;
                dph_n.valid = 1'b0;
                if (decode_c) begin
                    if (!ok_c) begin
                        state_n = ST_ERR1;
                        ready_n = 1'b0;
                        resp_n  = HRESP_ERROR;
                    end else begin
                        dph_n.valid = 1'b1;
                        dph_n.write = bus.hwrite;
                        dph_n.be    = be_c;
                        dph_word_n  = word_c;
                        // Read colliding with a completing write costs one extra wait
                        if (!bus.hwrite && wr_now_c) begin
                            pending_n = 1'b1;
                            state_n   = ST_WAIT;
                            cnt_n     = WS_FULL;
                            ready_n   = 1'b0;
                        end else if (HAS_WAIT) begin
                            state_n = ST_WAIT;
                            cnt_n   = WS_LESS;
                            ready_n = 1'b0;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            dph       <= '0;
            dph_word  <= '0;
            pending   <= 1'b0;
            rd_cap    <= 1'b0;
            ready_reg <= 1'b1;
            resp_reg  <= HRESP_OKAY;
            rdata_reg <= 32'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            dph       <= dph_n;
            dph_word  <= dph_word_n;
            pending   <= pending_n;
            rd_cap    <= mem_cs & ~mem_we;
            ready_reg <= ready_n;
            resp_reg  <= resp_n;
            if (rd_cap) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

    assign bus.hreadyout = ready_reg;
    assign bus.hresp     = resp_reg;
    assign bus.hrdata    = rdata_reg;

endmodule
